// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// The full-adder cell lives here so every serial datapath uses the same equation.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Returns {sum, carry_out} for one bit position.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        return {s, co};
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One full-adder cell plus the carry flip-flop that threads the carry
// between successive bit positions of a serial add or subtract.
module serial_fa_bit
    import serial_arith_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic init,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic s,
    output logic cn
);

    logic c;
    logic [1:0] fa;

    assign fa = full_add(a, b, c);
    assign s  = fa[1];
    assign cn = fa[0];

    // Carry register: cleared on reset, seeded with the mode bit on load
    // (carry-in of 1 completes the two's complement for subtraction),
    // then advanced with the cell's carry-out on every processed bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
        end else if (load) begin
            c <= init;
        end else if (en) begin
            c <= cn;
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are consumed LSB first, one bit per
// clock, through a single full-adder cell. A start/busy/done handshake frames
// each operation; result and overflow are registered and held until the next one.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state;
    state_t next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CNT_W-1:0] cnt;
    logic             cm;
    logic             sub_reg;
    logic             s;
    logic             cn;
    logic             load;
    logic             shift_en;
    logic             last_bit;
    logic             msb_in;

    assign load     = (state == IDLE) && start;
    assign shift_en = (state == SHIFT);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign msb_in   = (cnt == CNT_W'(WIDTH - 2));
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    serial_fa_bit u_fa (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .init (sub),
        .en   (shift_en),
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .s    (s),
        .cn   (cn)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state logic: IDLE waits for start, SHIFT runs WIDTH bits, DONE lasts one cycle.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = SHIFT;
            SHIFT:   if (last_bit) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per SHIFT cycle, and
    // capture the final result on the last bit so it appears together with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            cnt     <= '0;
            cm      <= 1'b0;
            sub_reg <= 1'b0;
            out     <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            a_reg   <= x;
            b_reg   <= (sub == MODE_SUB) ? ~y : y;
            sub_reg <= sub;
            cnt     <= '0;
            sum_reg <= '0;
        end else if (shift_en) begin
            sum_reg <= {s, sum_reg[WIDTH-1:1]};
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            cnt     <= cnt + 1'b1;
            if (msb_in) begin
                cm <= cn;
            end
            if (last_bit) begin
                out <= {((sub_reg == MODE_SUB) ? ~cn : cn), s, sum_reg[WIDTH-1:1]};
                ovf <= cm ^ cn;
            end
        end
    end

endmodule
